wb_host_master: RTL and testbench
=================================

# wb_host_master

Wishbone classic single-transfer initiator that drives the user project's slave port (`wbs_*`) from a simple command/response stream. It sits beside `user_proj_example` inside the wrapper and lets a local controller (logic-analyzer or IO-pin command path) issue 32-bit reads and writes without the management SoC. Every transfer is bounded by a watchdog that reports a bus error instead of hanging.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte-select width is `DATA_W/8`
- `TIMEOUT`, 255, maximum cycles with `stb` high before the transfer aborts (1..65535)

- `wb_clk_i`  in  1  clock; one clock domain, all logic on rising edge
- `wb_rst_ni`  in  1  asynchronous, active-low reset
- `cmd_valid_i`  in  1  command offered
- `cmd_ready_o`  out  1  command accepted when high with `cmd_valid_i`
- `cmd_we_i`  in  1  1 = write, 0 = read
- `cmd_adr_i`  in  ADDR_W  byte address
- `cmd_dat_i`  in  DATA_W  write data
- `cmd_sel_i`  in  DATA_W/8  byte enables
- `rsp_valid_o`  out  1  response available
- `rsp_ready_i`  in  1  response consumed when high with `rsp_valid_o`
- `rsp_dat_o`  out  DATA_W  read data; 0 for writes and errors
- `rsp_err_o`  out  1  1 = timeout abort
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1  Wishbone strobes
- `wbm_adr_o`  out  ADDR_W; `wbm_dat_o`  out  DATA_W; `wbm_sel_o`  out  DATA_W/8
- `wbm_dat_i`  in  DATA_W; `wbm_ack_i`  in  1  slave return
- `busy_o`  out  1  high in any state other than IDLE

## Operation
- FSM: IDLE -> BUS -> RESP -> IDLE.
- IDLE: `cmd_ready_o`=1. On `cmd_valid_i`, register we/adr/dat/sel, clear the watchdog, go to BUS.
- BUS: `wbm_cyc_o`=`wbm_stb_o`=1, address/data/sel/we held stable from the registered command. Watchdog increments each cycle.
  - `wbm_ack_i`=1: capture `wbm_dat_i` (reads) or 0 (writes), `rsp_err_o`=0, go to RESP.
  - Watchdog reaches `TIMEOUT - 1` without ack: `rsp_dat_o`=0, `rsp_err_o`=1, go to RESP.
  - Ack and watchdog expiry in the same cycle: ack wins, no error.
- RESP: `rsp_valid_o`=1, response held stable until `rsp_ready_i`, then IDLE.
- `wbm_ack_i` outside BUS is ignored. Each command produces exactly one response. Only one transfer is outstanding.
- Reset values: all outputs 0 except `cmd_ready_o`. `cmd_ready_o` goes to 1 on the first clock after reset release. The FSM enters IDLE.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Command accepted at edge N: `cyc`/`stb` high from N+1.
- Ack sampled at edge M: `cyc`/`stb` low and `rsp_valid_o` high from M+1.
  - Zero-wait-state slave (ack in first BUS cycle): 2 cycles from command accept to response.
- Timeout: `stb` is high for exactly `TIMEOUT` cycles, then `rsp_valid_o` rises with `rsp_err_o`=1.
- `rsp_ready_i` sampled at edge R: IDLE and `cmd_ready_o`=1 from R+1.
  - Minimum command-to-command spacing is 3 cycles.
- `wb_rst_ni` low mid-transfer: `cyc`/`stb`/`rsp_valid_o` drop asynchronously. The pending command and response are discarded.

## Structure
- Shared package `wb_host_pkg`:
  - state enum `wbh_state_e` {IDLE, BUS, RESP}
  - default width constants
  - `WBH_TIMEOUT_DEF` = 255
- Single module. The watchdog is an inline `$clog2(TIMEOUT+1)`-bit counter. No sub-module is needed.

## Test plan
- Write 0x3000_0004 ← 0xCAFE_F00D, sel 4'hF, slave acks in first cycle:
  - bus shows we=1, adr/dat/sel correct for 1 cycle.
  - `rsp_valid_o` 2 cycles after accept, err=0, dat=0.
- Read 0x3000_0008, slave acks after 5 wait states with 0x1234_5678:
  - `stb` high 6 cycles.
  - `rsp_dat_o`=0x1234_5678, err=0.
- No ack, `TIMEOUT`=16:
  - `stb` high exactly 16 cycles.
  - `rsp_err_o`=1, `rsp_dat_o`=0.
  - Next command accepted normally.
- Ack in the same cycle the watchdog expires (`TIMEOUT`=16, ack on cycle 16): err=0, data captured.
- Backpressure: hold `rsp_ready_i`=0 for 10 cycles:
  - response stable throughout.
  - `cmd_ready_o`=0 throughout.
  - Spurious `wbm_ack_i` pulses during this window are ignored.
- Assert `wb_rst_ni` low during BUS: `cyc`/`stb` drop without a clock edge. After release, a no-response-leak check: no `rsp_valid_o` appears.

Source files
------------

// File: rtl/wb_host_master_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// wb_host_pkg: shared types and default widths for the Wishbone host master
// Revision: 1.0
// ------------------------------------------------------------------------
package wb_host_pkg;

  localparam int WBH_ADDR_W_DEF  = 32;
  localparam int WBH_DATA_W_DEF  = 32;
  localparam int WBH_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbh_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_host_master_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// wb_host_master_if: command/response stream plus Wishbone initiator bus
// Revision: 1.0
// ------------------------------------------------------------------------
interface wb_host_master_if
  import wb_host_pkg::*;
#(
  parameter int ADDR_W = WBH_ADDR_W_DEF,
  parameter int DATA_W = WBH_DATA_W_DEF
) ();

  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic                cmd_we_i;
  logic [ADDR_W-1:0]   cmd_adr_i;
  logic [DATA_W-1:0]   cmd_dat_i;
  logic [DATA_W/8-1:0] cmd_sel_i;

  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [DATA_W-1:0]   rsp_dat_o;
  logic                rsp_err_o;

  logic                wbm_cyc_o;
  logic                wbm_stb_o;
  logic                wbm_we_o;
  logic [ADDR_W-1:0]   wbm_adr_o;
  logic [DATA_W-1:0]   wbm_dat_o;
  logic [DATA_W/8-1:0] wbm_sel_o;
  logic [DATA_W-1:0]   wbm_dat_i;
  logic                wbm_ack_i;

  // master = the host-master block; slave = the controller / bus side
  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  rsp_ready_i, wbm_dat_i, wbm_ack_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output rsp_ready_i, wbm_dat_i, wbm_ack_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
  );

endinterface
`default_nettype wire

// File: rtl/wb_host_master.sv
`default_nettype none
// ------------------------------------------------------------------------
// wb_host_master: Wishbone classic single-transfer initiator with watchdog
// Revision: 1.0
// ------------------------------------------------------------------------
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int ADDR_W  = WBH_ADDR_W_DEF,
  parameter int DATA_W  = WBH_DATA_W_DEF,
  parameter int TIMEOUT = WBH_TIMEOUT_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  wb_host_master_if.master bus_if,
  output logic             busy_o
);

  localparam int              SEL_W   = DATA_W / 8;
  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  wbh_state_e        state_q, state_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cyc_q, cyc_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;

  logic w_accept, w_ack, w_expire;

  // Acceptance keys off the registered ready so nothing is taken the cycle after reset
  assign w_accept = (state_q == IDLE) && cmd_ready_q && bus_if.cmd_valid_i;
  assign w_ack    = (state_q == BUS) && bus_if.wbm_ack_i;
  assign w_expire = (state_q == BUS) && (wdog_q == WD_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      wdog_q      <= '0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cyc_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cyc_q       <= cyc_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_accept) state_d = BUS;
      BUS:     if (w_ack || w_expire) state_d = RESP;
      RESP:    if (bus_if.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so their next values derive from state_d
  always_comb begin
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    wdog_d      = wdog_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    if (w_accept) begin
      we_d   = bus_if.cmd_we_i;
      adr_d  = bus_if.cmd_adr_i;
      dat_d  = bus_if.cmd_dat_i;
      sel_d  = bus_if.cmd_sel_i;
      wdog_d = '0;
    end else if (state_q == BUS) begin
      wdog_d = wdog_q + WD_W'(1);
    end

    // Ack beats a simultaneous watchdog expiry
    if (w_ack) begin
      rsp_dat_d = we_q ? '0 : bus_if.wbm_dat_i;
      rsp_err_d = 1'b0;
    end else if (w_expire) begin
      rsp_dat_d = '0;
      rsp_err_d = 1'b1;
    end

    cyc_d       = (state_d == BUS);
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  assign bus_if.cmd_ready_o = cmd_ready_q;
  assign bus_if.rsp_valid_o = rsp_valid_q;
  assign bus_if.rsp_dat_o   = rsp_dat_q;
  assign bus_if.rsp_err_o   = rsp_err_q;
  assign bus_if.wbm_cyc_o   = cyc_q;
  assign bus_if.wbm_stb_o   = cyc_q;
  assign bus_if.wbm_we_o    = we_q;
  assign bus_if.wbm_adr_o   = adr_q;
  assign bus_if.wbm_dat_o   = dat_q;
  assign bus_if.wbm_sel_o   = sel_q;
  assign busy_o             = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_host_master.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_wb_host_master: directed self-checking bench for wb_host_master
// Revision: 1.0
// ------------------------------------------------------------------------
module tb_wb_host_master;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks   = 0;
  int   failures = 0;

  wb_host_master_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  wb_host_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus_if    (bus_if),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus_if.cmd_valid_i = 1'b0;
    bus_if.cmd_we_i    = 1'b0;
    bus_if.cmd_adr_i   = '0;
    bus_if.cmd_dat_i   = '0;
    bus_if.cmd_sel_i   = '0;
    bus_if.rsp_ready_i = 1'b0;
    bus_if.wbm_dat_i   = '0;
    bus_if.wbm_ack_i   = 1'b0;
  endtask

  // Waits (bounded) for ready, offers one command, returns at the negedge after acceptance
  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    int n = 0;
    while (bus_if.cmd_ready_o !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus_if.cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready_wait got=%b want=1", bus_if.cmd_ready_o);
    end
    bus_if.cmd_we_i    = we;
    bus_if.cmd_adr_i   = adr;
    bus_if.cmd_dat_i   = dat;
    bus_if.cmd_sel_i   = sel;
    bus_if.cmd_valid_i = 1'b1;
    @(negedge clk);
    bus_if.cmd_valid_i = 1'b0;
  endtask

  // Counts cycles with stb high; ack is raised on cycle ack_on (0 = never)
  task automatic run_bus(input int ack_on, output int stb_cycles);
    stb_cycles = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus_if.wbm_stb_o !== 1'b1) break;
      stb_cycles++;
      bus_if.wbm_ack_i = (k == ack_on);
      @(negedge clk);
      bus_if.wbm_ack_i = 1'b0;
    end
  endtask

  task automatic consume_rsp();
    bus_if.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_if.cmd_ready_o, bus_if.rsp_valid_o, bus_if.rsp_err_o, bus_if.wbm_cyc_o,
         bus_if.wbm_stb_o, bus_if.wbm_we_o, busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0000000", {bus_if.cmd_ready_o, bus_if.rsp_valid_o,
               bus_if.rsp_err_o, bus_if.wbm_cyc_o, bus_if.wbm_stb_o, bus_if.wbm_we_o, busy});
    end
    checks++;
    if ({bus_if.rsp_dat_o, bus_if.wbm_adr_o, bus_if.wbm_dat_o, bus_if.wbm_sel_o} !== 100'b0) begin
      failures++;
      $display("FAIL reset_data got=%h want=0", {bus_if.rsp_dat_o, bus_if.wbm_adr_o,
               bus_if.wbm_dat_o, bus_if.wbm_sel_o});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus_if.cmd_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge got=%b want=0", bus_if.cmd_ready_o);
    end
    @(negedge clk);
    checks++;
    if ({bus_if.cmd_ready_o, busy} !== 2'b10) begin
      failures++;
      $display("FAIL ready_after_release got=%b want=10", {bus_if.cmd_ready_o, busy});
    end
  endtask

  task automatic test_write_zero_wait();
    bus_if.wbm_dat_i = 32'hDEAD_BEEF;
    send_cmd(1'b1, 32'h3000_0004, 32'hCAFE_F00D, 4'hF);
    checks++;
    if ({bus_if.wbm_cyc_o, bus_if.wbm_stb_o, bus_if.wbm_we_o, busy, bus_if.rsp_valid_o,
         bus_if.cmd_ready_o} !== 6'b111100) begin
      failures++;
      $display("FAIL wr_bus_ctrl got=%b want=111100", {bus_if.wbm_cyc_o, bus_if.wbm_stb_o,
               bus_if.wbm_we_o, busy, bus_if.rsp_valid_o, bus_if.cmd_ready_o});
    end
    checks++;
    if ({bus_if.wbm_adr_o, bus_if.wbm_dat_o, bus_if.wbm_sel_o} !== {32'h3000_0004, 32'hCAFE_F00D, 4'hF}) begin
      failures++;
      $display("FAIL wr_bus_fields got=%h want=%h", {bus_if.wbm_adr_o, bus_if.wbm_dat_o,
               bus_if.wbm_sel_o}, {32'h3000_0004, 32'hCAFE_F00D, 4'hF});
    end
    bus_if.wbm_ack_i = 1'b1;
    @(negedge clk);
    bus_if.wbm_ack_i = 1'b0;
    checks++;
    if ({bus_if.wbm_cyc_o, bus_if.wbm_stb_o, bus_if.rsp_valid_o, bus_if.rsp_err_o} !== 4'b0010) begin
      failures++;
      $display("FAIL wr_rsp_ctrl got=%b want=0010", {bus_if.wbm_cyc_o, bus_if.wbm_stb_o,
               bus_if.rsp_valid_o, bus_if.rsp_err_o});
    end
    checks++;
    if (bus_if.rsp_dat_o !== 32'h0) begin
      failures++;
      $display("FAIL wr_rsp_dat got=%h want=00000000", bus_if.rsp_dat_o);
    end
    consume_rsp();
    checks++;
    if ({bus_if.cmd_ready_o, bus_if.rsp_valid_o, busy} !== 3'b100) begin
      failures++;
      $display("FAIL wr_return_idle got=%b want=100", {bus_if.cmd_ready_o, bus_if.rsp_valid_o, busy});
    end
  endtask

  task automatic test_read_wait_states();
    int n;
    bus_if.wbm_dat_i = 32'h1234_5678;
    send_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    checks++;
    if ({bus_if.wbm_we_o, bus_if.wbm_adr_o} !== {1'b0, 32'h3000_0008}) begin
      failures++;
      $display("FAIL rd_bus_fields got=%h want=%h", {bus_if.wbm_we_o, bus_if.wbm_adr_o},
               {1'b0, 32'h3000_0008});
    end
    run_bus(6, n);
    checks++;
    if (n !== 6) begin
      failures++;
      $display("FAIL rd_stb_cycles got=%0d want=6", n);
    end
    checks++;
    if ({bus_if.rsp_valid_o, bus_if.rsp_err_o, bus_if.rsp_dat_o} !== {2'b10, 32'h1234_5678}) begin
      failures++;
      $display("FAIL rd_rsp got=%h want=%h", {bus_if.rsp_valid_o, bus_if.rsp_err_o,
               bus_if.rsp_dat_o}, {2'b10, 32'h1234_5678});
    end
    consume_rsp();
  endtask

  task automatic test_timeout();
    int n;
    bus_if.wbm_dat_i = 32'hA5A5_A5A5;
    send_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    run_bus(0, n);
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL to_stb_cycles got=%0d want=16", n);
    end
    checks++;
    if ({bus_if.rsp_valid_o, bus_if.rsp_err_o, bus_if.rsp_dat_o} !== {2'b11, 32'h0}) begin
      failures++;
      $display("FAIL to_rsp got=%h want=%h", {bus_if.rsp_valid_o, bus_if.rsp_err_o,
               bus_if.rsp_dat_o}, {2'b11, 32'h0});
    end
    consume_rsp();
  endtask

  task automatic test_ack_at_expiry();
    int n;
    bus_if.wbm_dat_i = 32'h0BAD_CAFE;
    send_cmd(1'b0, 32'h3000_0014, 32'h0, 4'h3);
    run_bus(16, n);
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL exp_stb_cycles got=%0d want=16", n);
    end
    checks++;
    if ({bus_if.rsp_valid_o, bus_if.rsp_err_o, bus_if.rsp_dat_o} !== {2'b10, 32'h0BAD_CAFE}) begin
      failures++;
      $display("FAIL exp_rsp got=%h want=%h", {bus_if.rsp_valid_o, bus_if.rsp_err_o,
               bus_if.rsp_dat_o}, {2'b10, 32'h0BAD_CAFE});
    end
    consume_rsp();
  endtask

  task automatic test_backpressure();
    int n;
    bus_if.wbm_dat_i = 32'h55AA_1234;
    send_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    run_bus(2, n);
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL bp_stb_cycles got=%0d want=2", n);
    end
    bus_if.wbm_dat_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus_if.rsp_valid_o, bus_if.rsp_err_o, bus_if.cmd_ready_o, bus_if.wbm_cyc_o,
           bus_if.rsp_dat_o} !== {4'b1000, 32'h55AA_1234}) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got=%h want=%h", i, {bus_if.rsp_valid_o,
                 bus_if.rsp_err_o, bus_if.cmd_ready_o, bus_if.wbm_cyc_o, bus_if.rsp_dat_o},
                 {4'b1000, 32'h55AA_1234});
      end
      bus_if.wbm_ack_i = (i % 2 == 0);
      @(negedge clk);
    end
    bus_if.wbm_ack_i = 1'b0;
    consume_rsp();
    checks++;
    if ({bus_if.cmd_ready_o, bus_if.rsp_valid_o} !== 2'b10) begin
      failures++;
      $display("FAIL bp_release got=%b want=10", {bus_if.cmd_ready_o, bus_if.rsp_valid_o});
    end
  endtask

  // Commands, acks and response-ready all held high: one transfer every 3 cycles
  task automatic test_back_to_back();
    logic [2:0] want;
    bus_if.cmd_we_i    = 1'b1;
    bus_if.cmd_adr_i   = 32'h3000_0030;
    bus_if.cmd_dat_i   = 32'h0000_00FF;
    bus_if.cmd_sel_i   = 4'h1;
    bus_if.cmd_valid_i = 1'b1;
    bus_if.wbm_ack_i   = 1'b1;
    bus_if.rsp_ready_i = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 9) bus_if.cmd_valid_i = 1'b0;
      want = (k % 3 == 1) ? 3'b010 : (k % 3 == 2) ? 3'b001 : 3'b100;
      checks++;
      if ({bus_if.cmd_ready_o, bus_if.wbm_stb_o, bus_if.rsp_valid_o} !== want) begin
        failures++;
        $display("FAIL b2b cycle=%0d got=%b want=%b", k, {bus_if.cmd_ready_o,
                 bus_if.wbm_stb_o, bus_if.rsp_valid_o}, want);
      end
    end
    bus_if.wbm_ack_i   = 1'b0;
    bus_if.rsp_ready_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_bus();
    send_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    checks++;
    if (bus_if.wbm_stb_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_stb got=%b want=1", bus_if.wbm_stb_o);
    end
    #2;
    rst_n = 1'b0;
    bus_if.wbm_ack_i = 1'b1;
    #1;
    checks++;
    if ({bus_if.wbm_cyc_o, bus_if.wbm_stb_o, bus_if.rsp_valid_o, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_async_drop got=%b want=0000", {bus_if.wbm_cyc_o, bus_if.wbm_stb_o,
               bus_if.rsp_valid_o, busy});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus_if.rsp_valid_o, bus_if.wbm_cyc_o} !== 2'b00) begin
        failures++;
        $display("FAIL rst_no_leak cycle=%0d got=%b want=00", i,
                 {bus_if.rsp_valid_o, bus_if.wbm_cyc_o});
      end
    end
    bus_if.wbm_ack_i = 1'b0;
    checks++;
    if (bus_if.cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready_back got=%b want=1", bus_if.cmd_ready_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_timeout();
    test_ack_at_expiry();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_bus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
